// File: rtl/mc_control_fsm.sv
// Multi-cycle control sequencer for the AND/OR/ADD, LW, SW, BEQ MIPS datapath.
// Steps each instruction through fetch/decode/execute/memory/write-back and halts on errors.
module mc_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_dst,
  output logic             alu_src,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic [1:0]       alu_op,
  output logic             mem_read,
  output logic             mem_write,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BEQ_EXEC  = 4'd9,
    S_HALT      = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [7:0] TIMEOUT  = 8'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] retire_q, retire_d;
  logic             halted_q, halted_d;
  logic             err_q, err_d;
  logic [1:0]       aop_q, aop_d;

  logic             retire;
  logic             go_halt;
  logic             fn_legal;
  logic [1:0]       fn_aop;

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q  <= S_IDLE;
      wait_q   <= '0;
      retire_q <= '0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
      aop_q    <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      retire_q <= retire_d;
      halted_q <= halted_d;
      err_q    <= err_d;
      aop_q    <= aop_d;
    end
  end

  always_comb begin
    fn_legal = 1'b1;
    fn_aop   = 2'b00;
    case (funct)
      FN_AND:  fn_aop = 2'b00;
      FN_OR:   fn_aop = 2'b01;
      FN_ADD:  fn_aop = 2'b10;
      default: fn_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    aop_d      = aop_q;
    retire     = 1'b0;
    go_halt    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_op     = 2'b00;
    mem_read   = 1'b0;
    mem_write  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_write = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      state_d = S_R_EXEC;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ:        state_d = S_BEQ_EXEC;
          default:       go_halt = 1'b1;
        endcase
      end
      S_R_EXEC: begin
        reg_dst = 1'b1;
        alu_op  = fn_aop;
        if (fn_legal) begin
          aop_d   = fn_aop;
          state_d = S_R_WB;
        end else begin
          go_halt = 1'b1;
        end
      end
      S_R_WB: begin
        // ALU op captured in R_EXEC so write-back does not re-decode funct
        reg_dst   = 1'b1;
        alu_op    = aop_q;
        reg_write = 1'b1;
        pc_write  = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src = 1'b1;
        alu_op  = 2'b10;
        wait_d  = '0;
        state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        alu_src  = 1'b1;
        alu_op   = 2'b10;
        mem_read = 1'b1;
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (wait_q + 8'd1 == TIMEOUT) begin
          go_halt = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        mem_read   = 1'b1;
        pc_write   = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        alu_src   = 1'b1;
        alu_op    = 2'b10;
        mem_write = 1'b1;
        if (mem_ready) begin
          pc_write = 1'b1;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else if (wait_q + 8'd1 == TIMEOUT) begin
          go_halt = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_BEQ_EXEC: begin
        alu_op   = 2'b11;
        pc_write = 1'b1;
        pc_src   = alu_zero;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (go_halt) state_d = S_HALT;
  end

  // Every entry into HALT is an error halt, so both flags set together
  assign halted_d = halted_q | go_halt;
  assign err_d    = err_q | go_halt;
  assign retire_d = retire ? retire_q + 1'b1 : retire_q;

  assign halted     = halted_q;
  assign err        = err_q;
  assign retire_cnt = retire_q;
  assign state      = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares the full control/status vector.
module tb_mc_control_fsm;

  logic       clk;
  logic       areset;
  logic       run;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       alu_zero;
  logic       mem_ready;
  logic       ir_write, pc_write, pc_src, reg_dst, alu_src, mem_to_reg, reg_write;
  logic [1:0] alu_op;
  logic       mem_read, mem_write, halted, err;
  logic [1:0] retire_cnt;
  logic [3:0] state;

  mc_control_fsm #(.MEM_TIMEOUT(15), .CNT_W(2)) dut (
    .clk(clk), .areset(areset), .run(run), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_dst(reg_dst), .alu_src(alu_src),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_op(alu_op),
    .mem_read(mem_read), .mem_write(mem_write), .halted(halted), .err(err),
    .retire_cnt(retire_cnt), .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam logic [3:0] ST_IDLE = 4'd0, ST_FETCH = 4'd1, ST_DEC = 4'd2, ST_MA = 4'd3,
                         ST_MR = 4'd4, ST_MWB = 4'd5, ST_MW = 4'd6, ST_REX = 4'd7,
                         ST_RWB = 4'd8, ST_BEQ = 4'd9, ST_HALT = 4'd10;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_BAD = 6'b001000;
  localparam logic [5:0] FN_AND = 6'b100100, FN_OR = 6'b100101, FN_ADD = 6'b100000,
                         FN_BAD = 6'b100010;

  typedef struct packed {
    logic [3:0]  st;
    logic [10:0] c;
    logic [1:0]  cnt;
    logic        h;
    logic        e;
  } exp_t;

  exp_t        q[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [1:0]  exp_cnt;

  // {ir_write, pc_write, pc_src, reg_dst, alu_src, mem_to_reg, reg_write, alu_op, mem_read, mem_write}
  function automatic logic [10:0] mk(input logic ir, pcw, pcs, rd, as, m2r, rw,
                                     input logic [1:0] aop, input logic mr, mw);
    return {ir, pcw, pcs, rd, as, m2r, rw, aop, mr, mw};
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t ex;
      exp_t ac;
      ex = q.pop_front();
      ac = {state, ir_write, pc_write, pc_src, reg_dst, alu_src, mem_to_reg, reg_write,
            alu_op, mem_read, mem_write, retire_cnt, halted, err};
      n_tests++;
      if (ac !== ex) begin
        n_fail++;
        $display("FAIL chk%0d: got st=%0d ctl=%b cnt=%0d halted=%b err=%b, want st=%0d ctl=%b cnt=%0d halted=%b err=%b",
                 n_tests, ac.st, ac.c, ac.cnt, ac.h, ac.e, ex.st, ex.c, ex.cnt, ex.h, ex.e);
      end
    end
  end

  task automatic cyc(input logic rn, rv, input logic [5:0] op, fn, input logic z, rdy,
                     input logic [3:0] st, input logic [10:0] c, input logic h, e);
    areset    = rn;
    run       = rv;
    opcode    = op;
    funct     = fn;
    alu_zero  = z;
    mem_ready = rdy;
    q.push_back(exp_t'({st, c, exp_cnt, h, e}));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    exp_cnt = '0;
    cyc(1'b0, 1'b1, OP_R, FN_ADD, 1'b0, 1'b1, ST_IDLE, '0, 1'b0, 1'b0);
  endtask

  task automatic idle_start();
    cyc(1'b1, 1'b1, OP_R, FN_ADD, 1'b0, 1'b0, ST_IDLE, '0, 1'b0, 1'b0);
  endtask

  // mem_ready held high through fetch/decode to show it is ignored there
  task automatic fd(input logic [5:0] op, fn);
    cyc(1'b1, 1'b0, op, fn, 1'b0, 1'b1, ST_FETCH, mk(1,0,0,0,0,0,0,2'b00,0,0), 1'b0, 1'b0);
    cyc(1'b1, 1'b0, op, fn, 1'b0, 1'b1, ST_DEC, '0, 1'b0, 1'b0);
  endtask

  task automatic do_r(input logic [5:0] fn, input logic [1:0] aop);
    fd(OP_R, fn);
    cyc(1'b1, 1'b0, OP_R, fn, 1'b0, 1'b0, ST_REX, mk(0,0,0,1,0,0,0,aop,0,0), 1'b0, 1'b0);
    cyc(1'b1, 1'b0, OP_R, fn, 1'b0, 1'b0, ST_RWB, mk(0,1,0,1,0,0,1,aop,0,0), 1'b0, 1'b0);
    exp_cnt++;
  endtask

  task automatic do_lw(input int unsigned nwait);
    fd(OP_LW, FN_ADD);
    cyc(1'b1, 1'b0, OP_LW, FN_ADD, 1'b0, 1'b1, ST_MA, mk(0,0,0,0,1,0,0,2'b10,0,0), 1'b0, 1'b0);
    for (int unsigned i = 0; i < nwait; i++)
      cyc(1'b1, 1'b0, OP_LW, FN_ADD, 1'b0, 1'b0, ST_MR, mk(0,0,0,0,1,0,0,2'b10,1,0), 1'b0, 1'b0);
    cyc(1'b1, 1'b0, OP_LW, FN_ADD, 1'b0, 1'b1, ST_MR, mk(0,0,0,0,1,0,0,2'b10,1,0), 1'b0, 1'b0);
    cyc(1'b1, 1'b0, OP_LW, FN_ADD, 1'b0, 1'b0, ST_MWB, mk(0,1,0,0,0,1,1,2'b00,1,0), 1'b0, 1'b0);
    exp_cnt++;
  endtask

  task automatic do_sw_ok();
    fd(OP_SW, FN_ADD);
    cyc(1'b1, 1'b0, OP_SW, FN_ADD, 1'b0, 1'b0, ST_MA, mk(0,0,0,0,1,0,0,2'b10,0,0), 1'b0, 1'b0);
    cyc(1'b1, 1'b0, OP_SW, FN_ADD, 1'b0, 1'b1, ST_MW, mk(0,1,0,0,1,0,0,2'b10,0,1), 1'b0, 1'b0);
    exp_cnt++;
  endtask

  task automatic do_beq(input logic z);
    fd(OP_BEQ, FN_ADD);
    cyc(1'b1, 1'b0, OP_BEQ, FN_ADD, z, 1'b0, ST_BEQ, mk(0,1,z,0,0,0,0,2'b11,0,0), 1'b0, 1'b0);
    exp_cnt++;
  endtask

  task automatic halt_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++)
      cyc(1'b1, 1'b1, OP_R, FN_ADD, 1'b0, 1'b1, ST_HALT, '0, 1'b1, 1'b1);
  endtask

  initial begin
    areset = 1'b0; run = 1'b0; opcode = '0; funct = '0;
    alu_zero = 1'b0; mem_ready = 1'b0; exp_cnt = '0;
    @(posedge clk);
    #1;

    do_reset();
    cyc(1'b1, 1'b0, OP_R, FN_ADD, 1'b0, 1'b0, ST_IDLE, '0, 1'b0, 1'b0);
    idle_start();
    do_r(FN_ADD, 2'b10);
    do_r(FN_OR, 2'b01);
    do_r(FN_AND, 2'b00);
    do_lw(3);
    do_sw_ok();
    do_beq(1'b1);
    do_beq(1'b0);

    fd(OP_SW, FN_ADD);
    cyc(1'b1, 1'b0, OP_SW, FN_ADD, 1'b0, 1'b0, ST_MA, mk(0,0,0,0,1,0,0,2'b10,0,0), 1'b0, 1'b0);
    for (int unsigned i = 0; i < 15; i++)
      cyc(1'b1, 1'b0, OP_SW, FN_ADD, 1'b0, 1'b0, ST_MW, mk(0,0,0,0,1,0,0,2'b10,0,1), 1'b0, 1'b0);
    halt_cycles(3);

    do_reset();
    idle_start();
    fd(OP_BAD, FN_ADD);
    halt_cycles(2);

    do_reset();
    idle_start();
    fd(OP_R, FN_BAD);
    cyc(1'b1, 1'b0, OP_R, FN_BAD, 1'b0, 1'b0, ST_REX, mk(0,0,0,1,0,0,0,2'b00,0,0), 1'b0, 1'b0);
    halt_cycles(2);

    do_reset();
    idle_start();
    do_beq(1'b1);
    fd(OP_LW, FN_ADD);
    cyc(1'b1, 1'b0, OP_LW, FN_ADD, 1'b0, 1'b0, ST_MA, mk(0,0,0,0,1,0,0,2'b10,0,0), 1'b0, 1'b0);
    cyc(1'b1, 1'b0, OP_LW, FN_ADD, 1'b0, 1'b0, ST_MR, mk(0,0,0,0,1,0,0,2'b10,1,0), 1'b0, 1'b0);
    cyc(1'b1, 1'b0, OP_LW, FN_ADD, 1'b0, 1'b0, ST_MR, mk(0,0,0,0,1,0,0,2'b10,1,0), 1'b0, 1'b0);
    do_reset();

    idle_start();
    for (int unsigned i = 0; i < 5; i++) do_beq(i[0]);
    cyc(1'b1, 1'b0, OP_R, FN_ADD, 1'b0, 1'b0, ST_FETCH, mk(1,0,0,0,0,0,0,2'b00,0,0), 1'b0, 1'b0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
